bcd_seq_display: RTL

- Sequential binary-to-BCD converter and seven-segment driver for the display node's 8-bit display buffer, replacing the combinational converter.
- Uses an iterative shift-add-3 (double-dabble) datapath: one bit per clock, start/done handshake.
- Registers the three digit segment outputs, so the display changes only on completed conversions (no glitching while the bus slave updates the buffer).

---
 rtl/bcd_seq_display.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bcd_seq_display.sv
// Sequential double-dabble binary-to-BCD converter with registered
// active-low seven-segment outputs and optional leading-zero blanking.
module bcd_seq_display #(
    parameter int DATA_WIDTH = 8,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  busy,
    output logic                  done,
    output logic [11:0]           bcd,
    output logic [6:0]            dout0,
    output logic [6:0]            dout1,
    output logic [6:0]            dout2
);

    localparam int SW = 12 + DATA_WIDTH;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_RST   = LZ_BLANK ? SEG_BLANK : SEG_ZERO;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [SW-1:0]           sr;
    logic [SW-1:0]           sr_nxt;
    logic [11:0]             adj;
    logic [3:0]              cnt;
    logic [DATA_WIDTH-1:0]   pend;
    logic                    pend_vld;
    logic                    load;
    logic [DATA_WIDTH-1:0]   load_val;
    logic [3:0]              hun;
    logic [3:0]              ten;
    logic [3:0]              uni;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign hun  = sr[SW-1 -: 4];
    assign ten  = sr[SW-5 -: 4];
    assign uni  = sr[SW-9 -: 4];
    assign busy = (state != IDLE);

    always_comb begin
        adj    = {add3(hun), add3(ten), add3(uni)};
        sr_nxt = {adj, sr[DATA_WIDTH-1:0]} << 1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // A strobe landing on DONE outranks any older pending value.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_val  = din;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 4'd1) state_nxt = DONE;
            end
            DONE: begin
                if (din_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else if (pend_vld) begin
                    load      = 1'b1;
                    load_val  = pend;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr       <= '0;
            cnt      <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            dout0    <= SEG_ZERO;
            dout1    <= SEG_RST;
            dout2    <= SEG_RST;
        end else begin
            done <= (state == DONE);
            if (load) begin
                sr  <= {12'b0, load_val};
                cnt <= 4'(DATA_WIDTH);
            end else if (state == SHIFT) begin
                sr  <= sr_nxt;
                cnt <= cnt - 4'd1;
            end
            if (state == SHIFT && din_valid) begin
                pend     <= din;
                pend_vld <= 1'b1;
            end else if (state == DONE) begin
                pend_vld <= 1'b0;
            end
            if (state == DONE) begin
                bcd   <= {hun, ten, uni};
                dout0 <= seg7(uni);
                dout1 <= (LZ_BLANK && hun == 4'd0 && ten == 4'd0) ?
                         SEG_BLANK : seg7(ten);
                dout2 <= (LZ_BLANK && hun == 4'd0) ? SEG_BLANK : seg7(hun);
            end
        end
    end

endmodule
